// File: rtl/fle_cfg_pkg.sv
// Shared types and sizing helpers for the fle configuration chain.
package fle_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_CHECK  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_ERROR  = 3'd4
  } fle_state_e;

  // Counter must hold TOTAL data bits plus the parity slot without wrapping.
  function automatic int cnt_width(input int total);
    return $clog2(total + 2);
  endfunction

endpackage

// File: rtl/fle_cfg_shift.sv
// TOTAL-bit shadow shift register; new bits enter at bit 0, tail is the MSB.
module fle_cfg_shift #(
  parameter int TOTAL = 80
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             i_en,
  input  logic             i_din,
  output logic [TOTAL-1:0] o_shadow,
  output logic             o_tail
);

  logic [TOTAL-1:0] r_sh;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)   r_sh <= '0;
    else if (i_en) r_sh <= {r_sh[TOTAL-2:0], i_din};
  end

  assign o_shadow = r_sh;
  assign o_tail   = r_sh[TOTAL-1];

endmodule

// File: rtl/fle_cfg_chain.sv
// Serial configuration chain: shifts a frame plus even-parity bit into a shadow
// register and commits it to the active configuration only if parity checks.
module fle_cfg_chain
  import fle_cfg_pkg::*;
#(
  parameter int NUM_FLE  = 4,
  parameter int CFG_BITS = 20
) (
  input  logic                        prog_clk,
  input  logic                        pReset,
  input  logic                        ccff_head,
  input  logic                        ccff_en,
  input  logic                        abort,
  output logic                        ccff_tail,
  output logic [NUM_FLE*CFG_BITS-1:0] cfg_out,
  output logic                        cfg_valid,
  output logic                        busy,
  output logic                        err
);

  localparam int TOTAL = NUM_FLE * CFG_BITS;
  localparam int CNT_W = cnt_width(TOTAL);
  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);

  fle_state_e       r_state, w_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_par;
  logic [TOTAL-1:0] r_cfg;
  logic             r_valid, r_err;
  logic             w_shift_en, w_par_cap;
  logic [TOTAL-1:0] w_shadow;
  logic             w_tail;

  fle_cfg_shift #(.TOTAL(TOTAL)) u_shift (
    .gclk     (prog_clk),
    .grst_n   (pReset),
    .i_en     (w_shift_en),
    .i_din    (ccff_head),
    .o_shadow (w_shadow),
    .o_tail   (w_tail)
  );

  // Abort outranks enable in SHIFT; once TOTAL bits are in, the next bit is parity.
  always_comb begin
    w_nxt      = r_state;
    w_shift_en = 1'b0;
    w_par_cap  = 1'b0;
    case (r_state)
      ST_IDLE: if (ccff_en) begin
        w_shift_en = 1'b1;
        w_nxt      = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (abort) w_nxt = ST_IDLE;
        else if (ccff_en) begin
          if (r_cnt == TOTAL_C) begin
            w_par_cap = 1'b1;
            w_nxt     = ST_CHECK;
          end else begin
            w_shift_en = 1'b1;
          end
        end
      end
      ST_CHECK:  w_nxt = ((^w_shadow) ^ r_par) ? ST_ERROR : ST_COMMIT;
      ST_COMMIT: w_nxt = ST_IDLE;
      ST_ERROR:  w_nxt = ST_IDLE;
      default:   w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_par   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_nxt == ST_IDLE)            r_cnt <= '0;
      else if (w_shift_en || w_par_cap) r_cnt <= r_cnt + 1'b1;
      if (w_par_cap) r_par <= ccff_head;
    end
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      r_cfg   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (r_state == ST_COMMIT) begin
      r_cfg   <= w_shadow;
      r_valid <= 1'b1;
      r_err   <= 1'b0;
    end else if (r_state == ST_ERROR) begin
      r_err   <= 1'b1;
    end
  end

  assign ccff_tail = w_tail;
  assign cfg_out   = r_cfg;
  assign cfg_valid = r_valid;
  assign err       = r_err;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fle_cfg_chain.sv
// Directed plus randomized frames on an 8-bit chain, checked against a frame-level model.
module tb_fle_cfg_chain;

  localparam int NF    = 2;
  localparam int CB    = 4;
  localparam int TOTAL = NF * CB;

  logic             prog_clk = 1'b0;
  logic             pReset   = 1'b0;
  logic             ccff_head = 1'b0;
  logic             ccff_en  = 1'b0;
  logic             abort    = 1'b0;
  logic             ccff_tail;
  logic [TOTAL-1:0] cfg_out;
  logic             cfg_valid, busy, err;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  // Model: committed config, flags, and the last TOTAL bits that entered the chain.
  logic [7:0] m_cfg = 8'h00;
  logic [7:0] m_sh  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_err   = 1'b0;

  fle_cfg_chain #(.NUM_FLE(NF), .CFG_BITS(CB)) dut (
    .prog_clk  (prog_clk),
    .pReset    (pReset),
    .ccff_head (ccff_head),
    .ccff_en   (ccff_en),
    .abort     (abort),
    .ccff_tail (ccff_tail),
    .cfg_out   (cfg_out),
    .cfg_valid (cfg_valid),
    .busy      (busy),
    .err       (err)
  );

  always #5 prog_clk = ~prog_clk;
  always @(posedge prog_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic hd, input logic ab);
    @(negedge prog_clk);
    ccff_en   = en;
    ccff_head = hd;
    abort     = ab;
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".cfg"},   32'(cfg_out),   32'(m_cfg));
    check({tag, ".valid"}, 32'(cfg_valid), 32'(m_valid));
    check({tag, ".err"},   32'(err),       32'(m_err));
    check({tag, ".busy"},  32'(busy),      32'(1'b0));
    check({tag, ".tail"},  32'(ccff_tail), 32'(m_sh[7]));
  endtask

  // Sends data MSB first, optional pause after bit pause_after, optional
  // enable held high through CHECK/COMMIT (must be ignored).
  task automatic send_frame(input string tag, input logic [7:0] d, input logic p,
                            input int pause_after, input int pause_len, input bit junk);
    int t0;
    int lat;
    bit done;
    t0 = 0;
    for (int i = 0; i < TOTAL; i++) begin
      step(1'b1, d[7-i], 1'b0);
      if (i == 0) t0 = cyc;
      m_sh = {m_sh[6:0], d[7-i]};
      if (i + 1 == pause_after)
        for (int k = 0; k < pause_len; k++) step(1'b0, 1'($urandom), 1'b0);
    end
    step(1'b1, p, 1'b0);
    check({tag, ".tail8"}, 32'(ccff_tail), 32'(d[7]));
    if (junk) begin
      step(1'b1, 1'($urandom), 1'b0);
      step(1'b1, 1'($urandom), 1'b0);
    end
    step(1'b0, 1'b0, 1'b0);
    done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (!busy) begin
        done = 1'b1;
        break;
      end
      @(negedge prog_clk);
    end
    lat = done ? (cyc - t0) : 999;
    check({tag, ".lat"}, 32'(lat), 32'(TOTAL + 3 + pause_len));
    if (((^d) ^ p) == 1'b0) begin
      m_cfg   = d;
      m_valid = 1'b1;
      m_err   = 1'b0;
    end else begin
      m_err = 1'b1;
    end
    check_outs(tag);
  endtask

  // n data bits, then abort asserted together with enable.
  task automatic abort_after(input string tag, input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      b = 1'($urandom);
      step(1'b1, b, 1'b0);
      m_sh = {m_sh[6:0], b};
    end
    step(1'b1, 1'($urandom), 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check_outs(tag);
  endtask

  initial begin
    logic [7:0] rd;
    logic       rp;
    #12;
    check_outs("reset");
    @(negedge prog_clk);
    pReset = 1'b1;

    send_frame("b2_p0", 8'hB2, 1'b0, 0, 0, 1'b0);
    send_frame("b2_p1", 8'hB2, 1'b1, 0, 0, 1'b0);
    send_frame("b2_pause", 8'hB2, 1'b0, 3, 5, 1'b0);
    abort_after("abort4", 4);
    send_frame("0f", 8'h0F, 1'b0, 0, 0, 1'b1);
    abort_after("abort8", 8);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 6; i++) step(1'b1, 1'($urandom), 1'b0);
    @(negedge prog_clk);
    ccff_en = 1'b0;
    #2 pReset = 1'b0;
    #1;
    m_cfg = 8'h00; m_sh = 8'h00; m_valid = 1'b0; m_err = 1'b0;
    check_outs("async_rst");
    @(negedge prog_clk);
    pReset = 1'b1;
    send_frame("55", 8'h55, 1'b0, 0, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      rd = 8'($urandom);
      rp = 1'($urandom);
      send_frame($sformatf("rnd%0d", r), rd, rp, int'($urandom_range(1, 8)),
                 int'($urandom_range(0, 4)), 1'($urandom));
      if ($urandom_range(0, 2) == 0)
        abort_after($sformatf("rabt%0d", r), int'($urandom_range(1, 8)));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
